// File: rtl/dmem_access_unit.sv
// RV32I data-memory access unit: load/store to req/gnt/rvalid transaction, lane steering, load extension.
// Stall spans IDLE+REQ+WAIT; mem_gnt/mem_rvalid backpressure stretches it, bounded by TIMEOUT_CYCLES.
module dmem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Stall,
  output logic        Misalign,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rword_q, rword_d;
  logic        berr_q, berr_d;

  logic        access;
  logic        illegal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;

  // Access legality and store lane steering, evaluated on the live strobes in IDLE.
  always_comb begin
    access = MemRead | MemWrite;
    case (Funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = Addr[0];
      3'b010:  illegal = |Addr[1:0];
      3'b100:  illegal = MemWrite;
      3'b101:  illegal = MemWrite | Addr[0];
      default: illegal = 1'b1;
    endcase
    case (Funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << Addr[1:0];
        wdata_new = {4{WrData[7:0]}};
      end
      2'b01: begin
        be_new    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{WrData[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = WrData;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rword_d = rword_q;
    berr_d  = berr_q;
    case (state_q)
      IDLE: begin
        if (access && !illegal) begin
          state_d = REQ;
          cnt_d   = 8'd0;
          we_d    = MemWrite;
          addr_d  = {Addr[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          f3_d    = Funct3;
          off_d   = Addr[1:0];
          rword_d = 32'd0;
          berr_d  = 1'b0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_gnt && we_q) begin
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          // A read grant on the last budget cycle still counts as incomplete.
          state_d = DONE;
          berr_d  = 1'b1;
        end else if (mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid) begin
          rword_d = mem_rdata;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          berr_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      rword_q <= 32'd0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rword_q <= rword_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    lane_b = rword_q[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? rword_q[31:16] : rword_q[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'd0, lane_b};
      3'b101:  load_val = {16'd0, lane_h};
      default: load_val = rword_q;
    endcase
  end

  // Stall and Misalign are gated by reset so both read 0 while it is held.
  assign Stall     = reset & (((state_q == IDLE) & access & ~illegal) | (state_q == REQ) | (state_q == WAIT));
  assign Misalign  = reset & (state_q == IDLE) & access & illegal;
  assign BusErr    = (state_q == DONE) & berr_q;
  assign RdData    = ((state_q == DONE) && !berr_q) ? load_val : 32'd0;
  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed store/load/misalign/timeout/reset scenarios plus randomized accesses.
module tb_dmem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wr_data, rd_data;
  logic        stall, misalign, bus_err;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        t_mem_read, t_mem_write;
  logic [2:0]  t_funct3;
  logic [31:0] t_addr, t_wr_data, t_rd_data;
  logic        t_stall, t_misalign, t_bus_err;
  logic        t_mem_req, t_mem_we, t_mem_gnt, t_mem_rvalid;
  logic [31:0] t_mem_addr, t_mem_wdata, t_mem_rdata;
  logic [3:0]  t_mem_be;

  int checks = 0;
  int errors = 0;

  dmem_access_unit u_dut (
    .clk(clk), .reset(reset), .MemRead(mem_read), .MemWrite(mem_write), .Funct3(funct3),
    .Addr(addr), .WrData(wr_data), .RdData(rd_data), .Stall(stall), .Misalign(misalign),
    .BusErr(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  dmem_access_unit #(.TIMEOUT_CYCLES(4)) u_dut_to (
    .clk(clk), .reset(reset), .MemRead(t_mem_read), .MemWrite(t_mem_write), .Funct3(t_funct3),
    .Addr(t_addr), .WrData(t_wr_data), .RdData(t_rd_data), .Stall(t_stall), .Misalign(t_misalign),
    .BusErr(t_bus_err), .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_be(t_mem_be),
    .mem_wdata(t_mem_wdata), .mem_gnt(t_mem_gnt), .mem_rvalid(t_mem_rvalid), .mem_rdata(t_mem_rdata)
  );

  // Reference model: access rules expressed as byte counts, masks and shifts.
  function automatic bit m_illegal(bit we, logic [2:0] f3, logic [31:0] a);
    int sz;
    if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
    if (we && f3 >= 3'd4) return 1'b1;
    sz = 1 << f3[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] a);
    int sz;
    sz = 1 << f3[1:0];
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] d);
    if (f3[1:0] == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (f3[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
    logic [63:0] v;
    int bits;
    bits = 8 * (1 << f3[1:0]);
    v = 64'(w >> (8 * (a % 4))) & ((64'd1 << bits) - 64'd1);
    if (!f3[2] && bits < 32 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return 32'(v);
  endfunction

  int          obs_stall, obs_req;
  bit          obs_done, obs_mis, obs_berr, obs_unstable, obs_we;
  logic [31:0] obs_res, obs_addr, obs_wdata, obs_idle_rd;
  logic [3:0]  obs_be;

  // Memory responder: grants on the (gd+1)th REQ cycle, returns data on the (rdl+1)th WAIT cycle.
  task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rw, input int gd, input int rdl, input int lim, input bit noise);
    int  waits;
    bit  granted;
    @(posedge clk); #1;
    mem_write = we; mem_read = ~we; funct3 = f3; addr = a; wr_data = wd;
    obs_stall = 0; obs_req = 0; obs_done = 0; obs_mis = 0; obs_berr = 0; obs_unstable = 0;
    obs_res = 0; obs_addr = 0; obs_wdata = 0; obs_be = 0; obs_we = 0; obs_idle_rd = 0;
    waits = 0; granted = 0;
    for (int c = 0; c < lim && !obs_done; c++) begin
      @(negedge clk);
      if (c == 0) begin obs_mis = misalign; obs_idle_rd = rd_data; end
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (stall) obs_stall++;
      if (mem_req) begin
        if (obs_req == 0) begin
          obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we;
        end else if (mem_addr !== obs_addr || mem_be !== obs_be || mem_wdata !== obs_wdata || mem_we !== obs_we) begin
          obs_unstable = 1'b1;
        end
        obs_req++;
        if (obs_req == gd + 1) begin
          mem_gnt = 1'b1; granted = 1'b1;
        end else if (noise) begin
          mem_rvalid = 1'($urandom_range(0, 1));
        end
      end else if (granted && stall) begin
        waits++;
        if (waits == rdl + 1) begin
          mem_rvalid = 1'b1; mem_rdata = rw;
        end else if (noise) begin
          mem_gnt = 1'($urandom_range(0, 1));
        end
      end else if (!stall && obs_stall > 0) begin
        obs_done = 1'b1; obs_res = rd_data; obs_berr = bus_err;
        mem_read = 1'b0; mem_write = 1'b0;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({rd_data, stall, misalign, bus_err, mem_req} !== 36'd0) begin
      errors++; $display("FAIL reset_status: got rd=%h stall=%b mis=%b berr=%b req=%b, expected all 0", rd_data, stall, misalign, bus_err, mem_req);
    end
    checks++;
    if ({mem_we, mem_addr, mem_be, mem_wdata} !== 69'd0) begin
      errors++; $display("FAIL reset_bus: got we=%b addr=%h be=%b wdata=%h, expected all 0", mem_we, mem_addr, mem_be, mem_wdata);
    end
    checks++;
    if ({t_stall, t_mem_req, t_bus_err, t_rd_data} !== 35'd0) begin
      errors++; $display("FAIL reset_to_inst: got stall=%b req=%b berr=%b rd=%h, expected 0", t_stall, t_mem_req, t_bus_err, t_rd_data);
    end
    reset = 1'b1;
  endtask

  task automatic test_store;
    logic [31:0] s_addr [3]  = '{32'h100, 32'h103, 32'h102};
    logic [31:0] s_wd   [3]  = '{32'hDEADBEEF, 32'h000000A5, 32'h00001234};
    logic [2:0]  s_f3   [3]  = '{3'b010, 3'b000, 3'b001};
    logic [3:0]  s_be   [3]  = '{4'b1111, 4'b1000, 4'b1100};
    logic [31:0] s_exp  [3]  = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'h12341234};
    for (int i = 0; i < 3; i++) begin
      do_access(1'b1, s_f3[i], s_addr[i], s_wd[i], 32'd0, 0, 0, 10, 1'b0);
      checks++;
      if (!obs_done || obs_stall != 2) begin
        errors++; $display("FAIL store_stall[%0d]: got done=%b stall_cycles=%0d, expected done=1 stall_cycles=2", i, obs_done, obs_stall);
      end
      checks++;
      if (obs_addr !== {s_addr[i][31:2], 2'b00} || obs_we !== 1'b1) begin
        errors++; $display("FAIL store_addr[%0d]: got addr=%h we=%b, expected addr=%h we=1", i, obs_addr, obs_we, {s_addr[i][31:2], 2'b00});
      end
      checks++;
      if (obs_be !== s_be[i] || obs_wdata !== s_exp[i]) begin
        errors++; $display("FAIL store_lanes[%0d]: got be=%b wdata=%h, expected be=%b wdata=%h", i, obs_be, obs_wdata, s_be[i], s_exp[i]);
      end
    end
  endtask

  task automatic test_load;
    logic [1:0]  l_off [6] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1};
    logic [2:0]  l_f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] l_exp [6] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01, 32'h0000007F};
    int          l_gd  [6] = '{2, 2, 2, 2, 2, 0};
    int          l_rd  [6] = '{2, 2, 2, 2, 2, 0};
    for (int i = 0; i < 6; i++) begin
      do_access(1'b0, l_f3[i], 32'h200 + 32'(l_off[i]), 32'h0, 32'h80FF7F01, l_gd[i], l_rd[i], 20, 1'b0);
      checks++;
      if (!obs_done || obs_stall != 3 + l_gd[i] + l_rd[i]) begin
        errors++; $display("FAIL load_stall[%0d]: got done=%b stall_cycles=%0d, expected %0d", i, obs_done, obs_stall, 3 + l_gd[i] + l_rd[i]);
      end
      checks++;
      if (obs_res !== l_exp[i] || obs_berr !== 1'b0 || obs_we !== 1'b0 || obs_addr !== 32'h200) begin
        errors++; $display("FAIL load_data[%0d]: got rd=%h berr=%b we=%b addr=%h, expected rd=%h berr=0 we=0 addr=00000200", i, obs_res, obs_berr, obs_we, obs_addr, l_exp[i]);
      end
    end
  endtask

  task automatic test_misalign;
    bit          m_we   [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  m_f3   [3] = '{3'b010, 3'b001, 3'b011};
    logic [31:0] m_addr [3] = '{32'h102, 32'h101, 32'h100};
    for (int i = 0; i < 3; i++) begin
      do_access(m_we[i], m_f3[i], m_addr[i], 32'h55, 32'h0, 0, 0, 3, 1'b0);
      checks++;
      if (obs_mis !== 1'b1 || obs_req != 0 || obs_stall != 0) begin
        errors++; $display("FAIL misalign[%0d]: got mis=%b req_cycles=%0d stall_cycles=%0d, expected 1/0/0", i, obs_mis, obs_req, obs_stall);
      end
    end
  endtask

  task automatic test_timeout;
    int n_req;
    bit seen, granted, done;
    n_req = 0; seen = 0;
    @(posedge clk); #1;
    t_mem_read = 1'b1; t_funct3 = 3'b010; t_addr = 32'h300; t_mem_gnt = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (t_mem_req) n_req++;
      else if (n_req > 0) begin
        seen = 1'b1; t_mem_read = 1'b0;
        checks++;
        if (t_bus_err !== 1'b1 || t_rd_data !== 32'd0 || t_stall !== 1'b0) begin
          errors++; $display("FAIL timeout_done: got berr=%b rd=%h stall=%b, expected 1/00000000/0", t_bus_err, t_rd_data, t_stall);
        end
      end
    end
    checks++;
    if (!seen || n_req != 4) begin
      errors++; $display("FAIL timeout_req_len: got seen=%b req_cycles=%0d, expected 1/4", seen, n_req);
    end
    @(negedge clk);
    checks++;
    if (t_bus_err !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: got berr=%b one cycle after, expected 0", t_bus_err);
    end
    granted = 0; done = 0;
    @(posedge clk); #1;
    t_mem_read = 1'b1; t_funct3 = 3'b010; t_addr = 32'h304;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      t_mem_gnt = 1'b0; t_mem_rvalid = 1'b0;
      if (t_mem_req) begin t_mem_gnt = 1'b1; granted = 1'b1; end
      else if (granted && t_stall) begin t_mem_rvalid = 1'b1; t_mem_rdata = 32'h13579BDF; end
      else if (granted) begin
        done = 1'b1; t_mem_read = 1'b0;
        checks++;
        if (t_rd_data !== 32'h13579BDF || t_bus_err !== 1'b0) begin
          errors++; $display("FAIL timeout_recover: got rd=%h berr=%b, expected 13579bdf/0", t_rd_data, t_bus_err);
        end
      end
    end
    t_mem_read = 1'b0; t_mem_gnt = 1'b0; t_mem_rvalid = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL timeout_recover_done: got done=0, expected 1");
    end
  endtask

  task automatic test_reset_mid;
    bit granted, in_wait;
    granted = 0; in_wait = 0;
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
    for (int c = 0; c < 10 && !in_wait; c++) begin
      @(negedge clk);
      mem_gnt = 1'b0;
      if (mem_req) begin mem_gnt = 1'b1; granted = 1'b1; end
      else if (granted && stall) in_wait = 1'b1;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (!in_wait || mem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got in_wait=%b req=%b stall=%b, expected 1/0/0", in_wait, mem_req, stall);
    end
    mem_read = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || rd_data !== 32'd0 || mem_req !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL late_rvalid: got stall=%b rd=%h req=%b berr=%b, expected 0", stall, rd_data, mem_req, bus_err);
    end
    do_access(1'b0, 3'b010, 32'h404, 32'h0, 32'h0BADF00D, 1, 1, 20, 1'b0);
    checks++;
    if (!obs_done || obs_res !== 32'h0BADF00D || obs_stall != 5) begin
      errors++; $display("FAIL reset_next_lw: got done=%b rd=%h stall_cycles=%0d, expected 1/0badf00d/5", obs_done, obs_res, obs_stall);
    end
  endtask

  task automatic test_random;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] a, wd, rw;
    int          gd, rdl, exp_stall;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      a = $urandom; wd = $urandom; rw = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      gd = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
      if (m_illegal(we, f3, a)) begin
        do_access(we, f3, a, wd, rw, gd, rdl, 3, 1'b1);
        checks++;
        if (obs_mis !== 1'b1 || obs_req != 0 || obs_stall != 0) begin
          errors++; $display("FAIL rand_illegal[%0d]: we=%b f3=%b a=%h got mis=%b req=%0d stall=%0d, expected 1/0/0", i, we, f3, a, obs_mis, obs_req, obs_stall);
        end
      end else begin
        do_access(we, f3, a, wd, rw, gd, rdl, 40, 1'b1);
        exp_stall = we ? 2 + gd : 3 + gd + rdl;
        checks++;
        if (!obs_done || obs_stall != exp_stall || obs_mis !== 1'b0 || obs_unstable || obs_idle_rd !== 32'd0) begin
          errors++; $display("FAIL rand_flow[%0d]: got done=%b stall=%0d mis=%b unstable=%b idle_rd=%h, expected 1/%0d/0/0/0", i, obs_done, obs_stall, obs_mis, obs_unstable, obs_idle_rd, exp_stall);
        end
        checks++;
        if (obs_addr !== (a & 32'hFFFFFFFC) || obs_we !== we || obs_berr !== 1'b0) begin
          errors++; $display("FAIL rand_req[%0d]: got addr=%h we=%b berr=%b, expected %h/%b/0", i, obs_addr, obs_we, obs_berr, a & 32'hFFFFFFFC, we);
        end
        if (we) begin
          checks++;
          if (obs_be !== m_be(f3, a) || obs_wdata !== m_wdata(f3, wd)) begin
            errors++; $display("FAIL rand_store[%0d]: f3=%b a=%h got be=%b wdata=%h, expected %b/%h", i, f3, a, obs_be, obs_wdata, m_be(f3, a), m_wdata(f3, wd));
          end
        end else begin
          checks++;
          if (obs_res !== m_load(f3, a, rw)) begin
            errors++; $display("FAIL rand_load[%0d]: f3=%b a=%h word=%h got rd=%h, expected %h", i, f3, a, rw, obs_res, m_load(f3, a, rw));
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wr_data = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    t_mem_read = 0; t_mem_write = 0; t_funct3 = 0; t_addr = 0; t_wr_data = 0;
    t_mem_gnt = 0; t_mem_rvalid = 0; t_mem_rdata = 0;
    repeat (3) @(posedge clk);
    test_reset;
    test_store;
    test_load;
    test_misalign;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
